zx_bus_dma_master: RTL
======================

// Module: zx_bus_dma_master
// PURPOSE
//  Parametrised hardware bus master that takes over the Z80 bus via BUSREQ/BUSACK and moves
//  blocks between Spectrum memory or I/O space and host-side valid/ready streams.
//  Generalises the fixed 16-bit Nios PIO loader path:
//   - configurable address/data width
//   - burst-limited bus tenure, so the Z80 regains the bus between bursts
//   - fill mode
//   - bus-acknowledge timeout and abort
//  Sits between the SD-loader CPU subsystem and the Z80 address/data/control pins.
// PARAMETERS
//  ADDR_W      16    target address width; address increments modulo 2**ADDR_W
//  DATA_W      8     data bus / stream width
//  LEN_W       17    transfer-length counter width (0..2**16 bytes)
//  BURST       64    max transfers per bus tenure before releasing bus_req_n
//  SETUP_CYC   1     clocks address/data stable before strobe
//  STROBE_CYC  4     clocks rd_n/wr_n asserted (>=1)
//  ACK_TMO     1024  clocks to wait for bus_ack_n low before error
// PORTS
//  clk_clk      in  1       system clock
//  reset_reset  in  1       asynchronous, active-high reset
//  cmd_start    in  1       1-clk pulse, accepted only when busy=0
//  cmd_mode     in  2       0=stream->mem write, 1=mem read->stream, 2=fill mem, 3=stream->I/O write
//  cmd_addr     in  ADDR_W  start address
//  cmd_len      in  LEN_W   number of transfers
//  cmd_fill     in  DATA_W  fill value (mode 2)
//  cmd_abort    in  1       level/pulse; stop at next cycle boundary
//  busy         out 1       command in progress
//  done         out 1       1-clk pulse at completion/abort/error
//  err          out 1       sticky ack timeout flag, cleared by next cmd_start
//  wr_data      in  DATA_W  write stream data
//  wr_valid     in  1       write stream valid
//  wr_ready     out 1       write stream ready
//  rd_data      out DATA_W  read stream data
//  rd_valid     out 1       read stream valid
//  rd_ready     in  1       read stream ready
//  bus_req_n    out 1       Z80 BUSREQ
//  bus_ack_n    in  1       Z80 BUSACK (asynchronous)
//  address      out ADDR_W  bus address
//  data_out     out DATA_W  bus write data
//  data_oe      out 1       bus data driver enable
//  data_in      in  DATA_W  bus read data
//  ctrl_bus     out 4       {mreq_n, iorq_n, rd_n, wr_n}
// BEHAVIOUR
//  Reset values:
//   - busy=0, done=0, err=0, wr_ready=0, rd_valid=0, rd_data=0
//   - bus_req_n=1, address=0, data_out=0, data_oe=0, ctrl_bus=4'hF
//  bus_ack_n passes through a 2-FF synchroniser; all decisions use the synchronised value.
//  FSM states:
//   - IDLE:  on cmd_start: latch mode/addr/len/fill; clear err; busy=1.
//            len=0 -> DONE directly; otherwise -> REQ.
//   - REQ:   bus_req_n=0; wait for sync ack=0 -> SETUP.
//            ACK_TMO clocks elapse -> set err -> RELEASE.
//   - SETUP: source data required before entry:
//             - modes 0/3: wait here with strobes high until a wr_valid&wr_ready beat is captured.
//               wr_ready is high for exactly one clk when the beat is taken.
//            Drive address; modes 0/2/3 also set data_oe=1 and data_out.
//            Enable mreq_n=0 (modes 0-2) or iorq_n=0 (mode 3).
//            Hold SETUP_CYC clks -> STROBE.
//   - STROBE: rd_n=0 (mode 1) or wr_n=0 for STROBE_CYC clks.
//             Mode 1 captures data_in on the last strobe clk.
//   - HOLD:  1 clk; strobes and mreq/iorq high, data_oe stays 1; then data_oe=0.
//            Decrement len, increment address (wraps), increment burst count.
//   - NEXT:  mode 1: present rd_data/rd_valid=1, stall until rd_ready.
//            Then:
//             - len=0 or abort pending -> RELEASE
//             - burst count=BURST -> RELEASE with re-request flag
//             - otherwise -> SETUP
//   - RELEASE: bus_req_n=1, data_oe=0; wait for sync ack=1.
//              Then -> REQ if re-request and len>0, else DONE.
//   - DONE:  done=1 for 1 clk, busy=0 -> IDLE.
//  Abort:
//   - latched when seen; never truncates an active strobe.
//   - in REQ: go straight to RELEASE.
//   - in IDLE: ignored.
//  cmd_start while busy is ignored.
//  Burst counter resets on each REQ entry.
//  Per-transfer latency (no stalls): SETUP_CYC+STROBE_CYC+2 clks.
//  Reset mid-transfer: all outputs return immediately to reset values (bus released, drivers off).
// STRUCTURE
//  Package zx_bus_pkg:
//   - mode enum (MODE_MEMWR/MEMRD/FILL/IOWR)
//   - FSM state enum
//   - ctrl_bus bit indices (CB_MREQ=3, CB_IORQ=2, CB_RD=1, CB_WR=0)
//  Sub-module zx_sync2: 2-FF synchroniser, reset value 1, used for bus_ack_n.
//  Remaining logic (FSM, counters, datapath) stays in this module.
// TESTING
//  1. Mode 0, addr=0x4000, len=3, stream AA,BB,CC, ack after 5 clks:
//     - 3 writes to 4000-4002, wr_n low 4 clks each, data_oe only inside cycles
//     - done pulse, bus_req_n=1
//  2. Mode 1, addr=0xFFFE, len=4, rd_ready toggling:
//     - reads FFFE, FFFF, 0000, 0001 (wrap)
//     - 4 rd beats in order; strobes idle while stalled
//  3. Mode 2, len=130, BURST=64, fill=0x00:
//     - bus released/re-requested twice (64+64+2)
//     - bus_req_n high until ack seen high each time
//  4. bus_ack_n held high:
//     - after ACK_TMO clks: err=1, bus_req_n=1, done pulse, no strobes
//  5. Abort asserted mid-STROBE of transfer 2 of 10:
//     - transfer 2 completes, then release, done
//     - address stops at base+2
//  6. Reset asserted during STROBE:
//     - same clk: ctrl_bus=F, data_oe=0, bus_req_n=1, busy=0
//     - len=0 start -> done next clk, bus never requested

Source files
------------

// File: rtl/zx_bus_pkg.sv
// Shared types for the Z80 bus DMA master: transfer modes, FSM states, ctrl_bus bit map.
package zx_bus_pkg;

  typedef enum logic [1:0] {
    MODE_MEMWR = 2'd0,
    MODE_MEMRD = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_IOWR  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_NEXT,
    ST_RELEASE,
    ST_DONE
  } state_e;

  localparam int CB_MREQ = 3;
  localparam int CB_IORQ = 2;
  localparam int CB_RD   = 1;
  localparam int CB_WR   = 0;

  // Modes whose bus data comes from the host write stream.
  function automatic logic needs_stream(input mode_e m);
    return (m == MODE_MEMWR) || (m == MODE_IOWR);
  endfunction

endpackage

// File: rtl/zx_sync2.sv
// Two-flop synchroniser for an asynchronous active-low input; idles high out of reset.
module zx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/zx_bus_dma_master.sv
// Z80 bus master: grabs the bus via BUSREQ/BUSACK and moves blocks between
// memory/I/O space and host valid/ready streams in burst-limited tenures.
module zx_bus_dma_master
  import zx_bus_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 17,
  parameter int BURST      = 64,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int ACK_TMO    = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_start,
  input  logic [1:0]        cmd_mode,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              bus_req_n,
  input  logic              bus_ack_n,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic [3:0]        ctrl_bus
);

  localparam int CYC_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int TMO_W   = $clog2(ACK_TMO + 1);
  localparam int BST_W   = $clog2(BURST + 1);

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   fill_q, wdat_q, rdat_q;
  logic                have_q, abort_q, rereq_q, err_q;
  logic [CYC_W-1:0]    cyc_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [BST_W-1:0]    burst_q;
  logic                ack_s, abort_pend, need_wr, src_ok, tmo_hit;

  zx_sync2 u_ack_sync (
    .clk (clk_clk),
    .rst (reset_reset),
    .d   (bus_ack_n),
    .q   (ack_s)
  );

  assign abort_pend = abort_q | cmd_abort;
  assign need_wr    = needs_stream(mode_q);
  assign src_ok     = !need_wr || have_q;
  assign address    = addr_q;
  assign rd_data    = rdat_q;
  assign err        = err_q;
  assign data_out   = data_oe ? ((mode_q == MODE_FILL) ? fill_q : wdat_q) : '0;

  // A stream beat is only taken on the way into (or while waiting in) SETUP,
  // so the setup count starts with data already in hand and no beat is
  // consumed for a transfer that will never run.
  assign wr_ready = need_wr && !have_q && wr_valid && (state_d == ST_SETUP);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tmo_hit   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    bus_req_n = 1'b0;
    data_oe   = 1'b0;
    rd_valid  = 1'b0;
    ctrl_bus  = 4'hF;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        bus_req_n = 1'b1;
        if (cmd_start) state_d = (cmd_len == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (abort_pend) state_d = ST_RELEASE;
        else if (!ack_s) state_d = ST_SETUP;
        else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
          tmo_hit = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_SETUP: begin
        if (src_ok) begin
          data_oe = (mode_q != MODE_MEMRD);
          if (mode_q == MODE_IOWR) ctrl_bus[CB_IORQ] = 1'b0;
          else                     ctrl_bus[CB_MREQ] = 1'b0;
          if (cyc_q == CYC_W'(SETUP_CYC - 1)) state_d = ST_STROBE;
        end else if (abort_pend) begin
          state_d = ST_RELEASE;
        end
      end
      ST_STROBE: begin
        data_oe = (mode_q != MODE_MEMRD);
        if (mode_q == MODE_IOWR) ctrl_bus[CB_IORQ] = 1'b0;
        else                     ctrl_bus[CB_MREQ] = 1'b0;
        if (mode_q == MODE_MEMRD) ctrl_bus[CB_RD] = 1'b0;
        else                      ctrl_bus[CB_WR] = 1'b0;
        if (cyc_q == CYC_W'(STROBE_CYC - 1)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        data_oe = (mode_q != MODE_MEMRD);
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        rd_valid = (mode_q == MODE_MEMRD);
        if ((mode_q != MODE_MEMRD) || rd_ready) begin
          if ((len_q == '0) || abort_pend)       state_d = ST_RELEASE;
          else if (burst_q == BST_W'(BURST))     state_d = ST_RELEASE;
          else                                   state_d = ST_SETUP;
        end
      end
      ST_RELEASE: begin
        bus_req_n = 1'b1;
        if (ack_s) state_d = (rereq_q && (len_q != '0) && !abort_pend) ? ST_REQ : ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        bus_req_n = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mode_q  <= MODE_MEMWR;
      addr_q  <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      have_q  <= 1'b0;
      abort_q <= 1'b0;
      rereq_q <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      tmo_q   <= '0;
      burst_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cmd_start) begin
        mode_q  <= mode_e'(cmd_mode);
        addr_q  <= cmd_addr;
        len_q   <= cmd_len;
        fill_q  <= cmd_fill;
        err_q   <= 1'b0;
        abort_q <= 1'b0;
        have_q  <= 1'b0;
      end
      if (cmd_abort && state_q != ST_IDLE && state_q != ST_DONE) abort_q <= 1'b1;
      if (wr_ready) begin
        wdat_q <= wr_data;
        have_q <= 1'b1;
      end
      if (state_q == ST_STROBE && mode_q == MODE_MEMRD && cyc_q == CYC_W'(STROBE_CYC - 1))
        rdat_q <= data_in;
      if (state_q == ST_HOLD) begin
        len_q   <= len_q - 1'b1;
        addr_q  <= addr_q + 1'b1;
        burst_q <= burst_q + 1'b1;
        have_q  <= 1'b0;
      end
      if (state_q == ST_REQ) begin
        burst_q <= '0;
        rereq_q <= 1'b0;
      end
      if (state_q == ST_NEXT && state_d == ST_RELEASE) rereq_q <= (burst_q == BST_W'(BURST));
      if (tmo_hit) err_q <= 1'b1;
      tmo_q <= (state_q == ST_REQ) ? tmo_q + 1'b1 : '0;
      // Setup/strobe count restarts on every state change and while SETUP waits for data.
      cyc_q <= (state_d != state_q || !src_ok) ? '0 : cyc_q + 1'b1;
    end
  end

endmodule
